// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: core request/response handshake plus byte-wide synchronous memory port
interface mem_bus_master_if #(parameter int addrBusWidth = 8);
    logic                    reqValid, reqReady, reqWrite, reqWord;
    logic [addrBusWidth-1:0] reqAddr;
    logic [15:0]             reqData;
    logic                    rspValid;
    logic [15:0]             rspData;
    logic [addrBusWidth-1:0] memAddr;
    logic [7:0]              memDataOut, memDataIn;
    logic                    memWrite, memStrobe;
    modport master (
        input  reqValid, reqWrite, reqWord, reqAddr, reqData, memDataIn,
        output reqReady, rspValid, rspData, memAddr, memDataOut, memWrite, memStrobe
    );
    modport slave (
        output reqValid, reqWrite, reqWord, reqAddr, reqData, memDataIn,
        input  reqReady, rspValid, rspData, memAddr, memDataOut, memWrite, memStrobe
    );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: sequences byte/word (big-endian) accesses onto a byte memory with one-cycle read latency
module mem_bus_master #(parameter int addrBusWidth = 8) (
    input logic              clk,
    input logic              reset,
    mem_bus_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, ACC_HI, ACC_LO, WAIT, RESP} state_t;
    localparam logic [addrBusWidth-1:0] ONE = 1;
    state_t                  state_q, state_d;
    logic                    wr_q, wr_d, word_q, word_d, accept;
    logic [addrBusWidth-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [15:0]             data_q, data_d, rsp_data_q, rsp_data_d;
    logic [7:0]              mem_dout_q, mem_dout_d;
    logic                    mem_wr_q, mem_wr_d, mem_stb_q, mem_stb_d, rsp_valid_q, rsp_valid_d;
    assign bus.reqReady   = reset & (state_q == IDLE);
    assign accept         = bus.reqValid & bus.reqReady;
    assign bus.memAddr    = mem_addr_q;
    assign bus.memDataOut = mem_dout_q;
    assign bus.memWrite   = mem_wr_q;
    assign bus.memStrobe  = mem_stb_q;
    assign bus.rspValid   = rsp_valid_q;
    assign bus.rspData    = rsp_data_q;
    always_comb begin
        case (state_q)
            IDLE:    state_d = accept ? ACC_HI : IDLE;
            ACC_HI:  state_d = word_q ? ACC_LO : wr_q ? RESP : WAIT;
            ACC_LO:  state_d = wr_q ? RESP : WAIT;
            WAIT:    state_d = RESP;
            default: state_d = IDLE;
        endcase
        wr_d        = accept ? bus.reqWrite : wr_q;
        word_d      = accept ? bus.reqWord : word_q;
        addr_d      = accept ? bus.reqAddr : addr_q;
        data_d      = accept ? bus.reqData : data_q;
        // Memory outputs are registered, so they are computed from the state being entered
        mem_stb_d   = state_d == ACC_HI || state_d == ACC_LO;
        mem_wr_d    = mem_stb_d & wr_d;
        mem_addr_d  = state_d == ACC_HI ? addr_d : state_d == ACC_LO ? addr_q + ONE : mem_addr_q;
        mem_dout_d  = state_d == ACC_HI ? (word_d ? data_d[15:8] : data_d[7:0]) :
                      state_d == ACC_LO ? data_q[7:0] : mem_dout_q;
        rsp_valid_d = state_d == RESP;
        rsp_data_d  = rsp_data_q;
        if (state_q == ACC_LO && !wr_q)
            rsp_data_d[15:8] = bus.memDataIn;
        if (state_q == WAIT)
            rsp_data_d = word_q ? {rsp_data_q[15:8], bus.memDataIn} : {8'h00, bus.memDataIn};
        if (state_d == RESP && wr_q)
            rsp_data_d = word_q ? data_q : {8'h00, data_q[7:0]};
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            word_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_stb_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            mem_stb_q   <= mem_stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the byte-wide synchronous memory port: addr, dataIn, dataOut, write, strobe.
- The memory registers dataOut one clock after a strobe.
- Accepts byte and word (big-endian, 2-byte) read/write requests over a valid/ready handshake and sequences the strobes.
- Captures the delayed read data and returns a single-cycle response to the core's fetch/execute logic.

Parameters:
- addrBusWidth, 8, width of memory address; word accesses wrap modulo 2^addrBusWidth.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request this cycle.
- reqWrite  in  1  1 = write, 0 = read.
- reqWord  in  1  1 = 16-bit access (two bytes), 0 = byte.
- reqAddr  in  addrBusWidth  start address.
- reqData  in  16  write data; byte writes use [7:0].
- rspValid  out  1  one-cycle completion pulse.
- rspData  out  16  read result, or written data for writes.
- memAddr  out  addrBusWidth  to memory addr.
- memDataOut  out  8  to memory dataIn.
- memDataIn  in  8  from memory dataOut.
- memWrite  out  1  to memory write.
- memStrobe  out  1  to memory strobe.

Behaviour:
- Clock is clk; reset is synchronous and active-low. With reset low at a posedge:
  - state = IDLE
  - memStrobe, memWrite, rspValid = 0
  - memAddr, memDataOut, rspData = 0
  - requests ignored
- reqReady = reset & (state == IDLE). It is combinational and is 0 whenever reset is low.
- Accept on posedge with reqValid & reqReady. The block latches write, word, addr and data.
- All mem* outputs and rspValid/rspData are registered.
- States: IDLE, ACC_HI, ACC_LO, WAIT, RESP. Transitions:
  - IDLE -> ACC_HI on accept.
  - ACC_HI -> ACC_LO if word; else -> RESP if write; else -> WAIT.
  - ACC_LO -> RESP if write, else -> WAIT.
  - WAIT -> RESP.
  - RESP -> IDLE.
- ACC_HI drives memStrobe=1, memAddr=A and memWrite=reqWrite. memDataOut = data[15:8] for a word, data[7:0] for a byte.
- ACC_LO drives memStrobe=1, memAddr=A+1 (truncated to addrBusWidth, so 0xFF -> 0x00 at the default width), memDataOut = data[7:0].
- IDLE, WAIT and RESP drive memStrobe=0 and memWrite=0. memAddr and memDataOut hold their last values.
- Read capture:
  - In ACC_LO of a word read: rspData[15:8] <= memDataIn (the byte from the ACC_HI strobe).
  - In WAIT: word read gives rspData[7:0] <= memDataIn; byte read gives rspData <= {8'h00, memDataIn}.
- Write response: rspData = {8'h00, data[7:0]} for a byte write, data[15:0] for a word write. It is loaded on entry to RESP.
- rspValid = 1 only in RESP, for exactly one cycle. rspData holds until the next response is loaded.
- Latency, accept edge = cycle 0:
  - Byte write: strobe in cycle 1, rspValid in cycle 2.
  - Word write: strobes in cycles 1-2, rspValid in cycle 3.
  - Byte read: strobe in cycle 1, rspValid in cycle 3.
  - Word read: strobes in cycles 1-2, rspValid in cycle 4.
- reqReady is 0 from cycle 1 through RESP and returns to 1 the cycle after RESP.
- Requests presented while busy are not accepted and must be held by the requester.
- reqValid is not sampled outside IDLE. Changes to req* fields after accept have no effect.
- Reset low mid-operation: the next posedge forces IDLE and memStrobe=0. No rspValid is produced for the aborted request.
- Writes to a ROM-configured memory complete normally; the master does not detect this.
- At most one strobe is issued per cycle. There are never two consecutive strobes except ACC_HI -> ACC_LO.

Test Plan:
- Byte read: mem[0x10]=0x5A; accept read byte @0x10. Expect memStrobe=1 only in cycle 1 with memAddr=0x10, memWrite=0. Expect rspValid in cycle 3 with rspData=0x005A.
- Word read wrap: mem[0xFF]=0x12, mem[0x00]=0x34; word read @0xFF. Expect strobes at 0xFF then 0x00 in cycles 1-2, and rspValid in cycle 4 with rspData=0x1234.
- Word write then readback: write 0xABCD @0x20. Expect memWrite=1 with data 0xAB @0x20, then 0xCD @0x21, and rspValid in cycle 3 with rspData=0xABCD. A word read @0x20 then returns 0xABCD.
- Back-to-back: hold reqValid=1 continuously with byte write 0x77 @0x05 then byte read @0x05. Expect reqReady=0 during busy, the second accept one cycle after the first rspValid, and a read response of 0x0077.
- Reset mid-access: assert reset low in cycle 2 of a word read. Expect memStrobe=0 and reqReady=0 at the next edge, no rspValid ever, and rspData=0x0000. After release, reqReady=1 and a new byte read completes normally.
- Reset state: hold reset low for 3 cycles with reqValid=1. Expect all outputs 0 and no strobe throughout.
